data_bus_arbiter: RTL

Two-master arbiter and transaction sequencer placed in front of `avalon_bus`. It shares the single data-bus port between the pipeline memory stage (master 0) and a secondary master (master 1, debug/DMA). It latches one request at a time, drives the bus strobes and address, honours `Waitreq` for multi-cycle devices such as the FP unit, and returns read data with a one-cycle completion pulse. Ties are resolved round-robin, and an optional watchdog aborts hung transactions.

---
 rtl/data_bus_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/data_bus_arbiter.sv
// data_bus_arbiter: round-robin arbiter and transaction sequencer sharing one data-bus port between two masters.
// Define BUS_TIMEOUT_EN to add a watchdog that aborts transactions stalled on Waitreq.
module data_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        M0Req,
  input  logic        M1Req,
  input  logic        M0Write,
  input  logic        M1Write,
  input  logic [15:0] M0Addr,
  input  logic [15:0] M1Addr,
  input  logic [15:0] M0WData,
  input  logic [15:0] M1WData,
  output logic [15:0] M0RData,
  output logic [15:0] M1RData,
  output logic        M0Done,
  output logic        M1Done,
  output logic        Error,
  output logic [1:0]  Grant,
  output logic [15:0] DataAddr,
  output logic [15:0] BusIn,
  output logic        ReadData,
  output logic        WriteData,
  input  logic [15:0] BusOut,
  input  logic        Waitreq
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state, state_next;
  logic [1:0]  grant, grant_next;
  logic        last_grant;
  logic [15:0] addr_l, wdata_l;
  logic        write_l;
  logic [15:0] rdata0, rdata1;
  logic        load, complete, abort, timeout_hit;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state      <= IDLE;
      grant      <= 2'b00;
      last_grant <= 1'b1;
    end else begin
      state <= state_next;
      grant <= grant_next;
      if (complete || abort)
        last_grant <= grant[1];
    end
  end

  always_comb begin
    state_next = state;
    grant_next = grant;
    load       = 1'b0;
    complete   = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (M0Req || M1Req) begin
          load       = 1'b1;
          state_next = ACCESS;
          // On a tie the master served last yields.
          if (M0Req && M1Req)
            grant_next = last_grant ? 2'b01 : 2'b10;
          else
            grant_next = M0Req ? 2'b01 : 2'b10;
        end
      end
      ACCESS: begin
        if (!Waitreq) begin
          complete   = 1'b1;
          state_next = RESP;
        end else if (timeout_hit) begin
          abort      = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        state_next = IDLE;
        grant_next = 2'b00;
      end
      default: begin
        state_next = IDLE;
        grant_next = 2'b00;
      end
    endcase
  end

  // Request fields are captured once at grant so the bus sees a stable transaction.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      addr_l  <= 16'h0000;
      wdata_l <= 16'h0000;
      write_l <= 1'b0;
    end else if (load) begin
      addr_l  <= grant_next[1] ? M1Addr  : M0Addr;
      wdata_l <= grant_next[1] ? M1WData : M0WData;
      write_l <= grant_next[1] ? M1Write : M0Write;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      rdata0 <= 16'h0000;
      rdata1 <= 16'h0000;
    end else if (!write_l && (complete || abort)) begin
      if (grant[0])
        rdata0 <= complete ? BusOut : 16'hDEAD;
      if (grant[1])
        rdata1 <= complete ? BusOut : 16'hDEAD;
    end
  end

`ifdef BUS_TIMEOUT_EN
  logic [3:0] wait_cnt;
  logic       err_l;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      wait_cnt <= 4'd0;
      err_l    <= 1'b0;
    end else begin
      if (load)
        wait_cnt <= 4'd0;
      else if (state == ACCESS && Waitreq && wait_cnt != 4'hF)
        wait_cnt <= wait_cnt + 4'd1;
      if (load)
        err_l <= 1'b0;
      else if (abort)
        err_l <= 1'b1;
    end
  end

  assign timeout_hit = (wait_cnt == 4'(TIMEOUT_CYCLES));
  assign Error       = (state == RESP) && err_l;
`else
  localparam logic [3:0] unused_timeout = 4'(TIMEOUT_CYCLES);
  assign timeout_hit = 1'b0;
  assign Error       = 1'b0;
`endif

  assign ReadData  = (state == ACCESS) && !write_l;
  assign WriteData = (state == ACCESS) && write_l;
  assign DataAddr  = addr_l;
  assign BusIn     = wdata_l;
  assign Grant     = grant;
  assign M0Done    = (state == RESP) && grant[0];
  assign M1Done    = (state == RESP) && grant[1];
  assign M0RData   = rdata0;
  assign M1RData   = rdata1;

endmodule
